weight_sink: RTL and testbench
==============================

Name: weight_sink

Overview:
- Receiving end of the weight coefficient stream. Consumes an ap_fifo-style stream of coefficients (dout/empty_n/read) and stores KERN_SIZE words in a local buffer.
- Once the buffer is full it serves the coefficients to a convolution core through a synchronous random-access read port.
- Sits between a weight streamer's output FIFO and the layer compute engine. A start pulse triggers a reload without reset.

Parameters:
- COEFF_WIDTH, 16, coefficient bit width (matches `coeff_width).
- KERN_SIZE, 288, number of coefficients per kernel set (matches `kern_s_*); must be >= 2.
- ADDR_W, $clog2(KERN_SIZE), derived read/write address width; not overridden.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst_n  in  1  synchronous, active-low reset.
- input_V_dout  in  COEFF_WIDTH  stream data, valid whenever input_V_empty_n=1.
- input_V_empty_n  in  1  stream has data.
- input_V_read  out  1  pop/accept strobe.
- start  in  1  single-cycle pulse: begin a load.
- busy  out  1  high while loading.
- done  out  1  high while the buffer holds a complete kernel set.
- load_count  out  ADDR_W+1  number of coefficients written in the current or last load.
- rd_ce  in  1  read enable.
- rd_addr  in  ADDR_W  read address.
- rd_q  out  COEFF_WIDTH  read data, registered.

Behaviour:
- FSM states: IDLE, LOAD, READY.
- Reset (ap_rst_n=0 at an edge): state=IDLE; busy=0; done=0; load_count=0; rd_q=0; input_V_read=0. Buffer contents are not cleared.
- IDLE:
  - start=1 -> LOAD next cycle; load_count<=0.
  - input_V_read is held 0.
- LOAD:
  - input_V_read = input_V_empty_n, combinational (first-word-fall-through semantics).
  - On each cycle with input_V_read=1: mem[load_count[ADDR_W-1:0]] <= input_V_dout, and load_count increments.
  - When a word is accepted with load_count==KERN_SIZE-1: load_count<=KERN_SIZE, state<=READY, done<=1 on the next cycle.
  - No extra word is popped in that cycle or after.
  - Stalls indefinitely with empty_n=0; no timeout.
  - start is ignored in this state.
- READY:
  - done=1, input_V_read=0.
  - start=1 -> LOAD: done<=0 and load_count<=0 on the next edge. This is a reload.
- busy = (state==LOAD), registered.
- Read port:
  - rd_ce=1 and rd_addr<KERN_SIZE -> rd_q<=mem[rd_addr]. Latency is exactly 1 cycle.
  - rd_ce=0, or rd_addr>=KERN_SIZE -> rd_q holds its value.
  - The read port is active in every state. The consumer gates use on done.
  - A read and a write to the same address in the same cycle return the old contents (read-first).
- Memory is a single inferred array of KERN_SIZE x COEFF_WIDTH with one write and one read port, synchronous.
- Reset mid-LOAD aborts the load. Partially written words remain, done=0, and the next start begins again at address 0.
- start coincident with reset: reset wins.

Test Plan:
- Reset, then start with KERN_SIZE=4 and a FIFO model preloaded with 0x0011,0x0022,0x0033,0x0044 -> input_V_read high for exactly 4 cycles; done=1 one cycle after the 4th pop; load_count=4; busy=0.
- After load, rd_ce=1 with rd_addr=2 -> rd_q=0x0033 on the following cycle. rd_addr=3 then rd_ce=0 -> rd_q stays 0x0044.
- Bursty source (empty_n toggling 1,0,0,1,1,0,1) -> exactly 4 pops, data stored in order, no pop while empty_n=0, no pop after the 4th word even with empty_n=1.
- Reload: in READY, pulse start with stream 0x0100..0x0103 -> done drops next cycle and returns after 4 pops; rd_addr=0 -> 0x0100. A start pulse during LOAD has no effect.
- ap_rst_n=0 after 2 of 4 words -> done=0, busy=0, load_count=0; a new start plus 4 words completes normally with correct contents.
- rd_addr=5 (>=KERN_SIZE) with rd_ce=1 -> rd_q unchanged; default KERN_SIZE=288 full load -> done after exactly 288 pops; mem[287] reads back correctly.

Source files
------------

// File: rtl/weight_sink.sv
// Coefficient sink: drains a first-word-fall-through stream into a KERN_SIZE-deep
// buffer, then serves the stored kernel set through a registered read port.
//
// state | meaning
// IDLE  | waiting for start after reset, buffer contents undefined/stale
// LOAD  | popping words from the stream into mem[load_count]
// READY | complete kernel set held, done asserted, start triggers a reload
module weight_sink #(
  parameter int COEFF_WIDTH = 16,
  parameter int KERN_SIZE   = 288,
  localparam int ADDR_W     = $clog2(KERN_SIZE)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [COEFF_WIDTH-1:0] input_V_dout,
  input  logic                   input_V_empty_n,
  output logic                   input_V_read,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W:0]        load_count,
  input  logic                   rd_ce,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [COEFF_WIDTH-1:0] rd_q
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  localparam logic [ADDR_W:0] KERN_N    = (ADDR_W+1)'(KERN_SIZE);
  localparam logic [ADDR_W:0] KERN_LAST = (ADDR_W+1)'(KERN_SIZE - 1);

  logic [1:0]             state;
  logic [COEFF_WIDTH-1:0] mem [0:KERN_SIZE-1];

  // Gated by reset so a reset landing mid-load never pops a word it then discards.
  assign input_V_read = ap_rst_n && (state == S_LOAD) && input_V_empty_n;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_LOAD;
            busy       <= 1'b1;
            load_count <= '0;
          end
        end
        S_LOAD: begin
          if (input_V_read) begin
            load_count <= load_count + 1'b1;
            if (load_count == KERN_LAST) begin
              state <= S_READY;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        S_READY: begin
          if (start) begin
            state      <= S_LOAD;
            busy       <= 1'b1;
            done       <= 1'b0;
            load_count <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (input_V_read) begin
      mem[load_count[ADDR_W-1:0]] <= input_V_dout;
    end
  end

  // Separate process from the write keeps same-address accesses read-first.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rd_q <= '0;
    end else if (rd_ce && ({1'b0, rd_addr} < KERN_N)) begin
      rd_q <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_weight_sink.sv
// Directed bench for weight_sink: a 4-deep instance against a queue-based FIFO
// model, and a default 288-deep instance against a counting source.
module tb_weight_sink;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [15:0] s_dout;
  logic        s_empty_n, s_read, s_start, s_busy, s_done, s_ce;
  logic [2:0]  s_cnt;
  logic [1:0]  s_addr;
  logic [15:0] s_q;

  logic [15:0] b_dout;
  logic        b_empty_n, b_read, b_start, b_busy, b_done, b_ce;
  logic [9:0]  b_cnt;
  logic [8:0]  b_addr;
  logic [15:0] b_q;

  weight_sink #(.COEFF_WIDTH(16), .KERN_SIZE(4)) u_small (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .input_V_dout(s_dout), .input_V_empty_n(s_empty_n), .input_V_read(s_read),
    .start(s_start), .busy(s_busy), .done(s_done), .load_count(s_cnt),
    .rd_ce(s_ce), .rd_addr(s_addr), .rd_q(s_q)
  );

  weight_sink #(.COEFF_WIDTH(16), .KERN_SIZE(288)) u_big (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .input_V_dout(b_dout), .input_V_empty_n(b_empty_n), .input_V_read(b_read),
    .start(b_start), .busy(b_busy), .done(b_done), .load_count(b_cnt),
    .rd_ce(b_ce), .rd_addr(b_addr), .rd_q(b_q)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] sq[$];
  int pops = 0;
  int viol = 0;
  int b_idx = 0;
  bit burst = 1'b0;
  int bidx = 0;
  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  // Source outputs change only on the falling edge, away from DUT sampling.
  always @(negedge clk) begin
    s_empty_n = (sq.size() > 0) && (!burst || pat[bidx]);
    s_dout    = (sq.size() > 0) ? sq[0] : 16'h0;
    if (burst) bidx = (bidx + 1) % 7;
    b_empty_n = 1'b1;
    b_dout    = 16'h8000 + 16'(b_idx);
  end

  always @(posedge clk) begin
    if (s_read) begin
      if (!s_empty_n) viol++;
      if (sq.size() > 0) void'(sq.pop_front());
      pops++;
    end
    if (b_read) b_idx++;
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pops(input int n, input int lim, input string tag);
    for (int i = 0; i < lim; i++) begin
      if (pops >= n) break;
      tick();
    end
    chk_eq(tag, 32'(pops >= n), 32'd1);
  endtask

  task automatic s_read_at(input logic [1:0] a, input logic [15:0] exp, input string tag);
    s_ce = 1'b1;
    s_addr = a;
    tick();
    chk_eq(tag, 32'(s_q), 32'(exp));
  endtask

  task automatic s_pulse();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    s_start = 1'b0; s_ce = 1'b0; s_addr = '0;
    b_start = 1'b0; b_ce = 1'b0; b_addr = '0;
    repeat (3) tick();
    chk_eq("rst_busy", 32'(s_busy), 32'd0);
    chk_eq("rst_done", 32'(s_done), 32'd0);
    chk_eq("rst_cnt",  32'(s_cnt),  32'd0);
    chk_eq("rst_q",    32'(s_q),    32'd0);
    chk_eq("rst_read", 32'(s_read), 32'd0);
    rst_n = 1'b1;
    tick();

    // Initial load of four words from a full FIFO.
    sq = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    pops = 0;
    tick();
    s_pulse();
    chk_eq("load_busy", 32'(s_busy), 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (pops >= 4) break;
      chk_eq("done_early", 32'(s_done), 32'd0);
      tick();
    end
    chk_eq("load_done", 32'(s_done), 32'd1);
    repeat (2) tick();
    chk_eq("load_pops", 32'(pops), 32'd4);
    chk_eq("load_cnt",  32'(s_cnt), 32'd4);
    chk_eq("load_idle_busy", 32'(s_busy), 32'd0);
    chk_eq("ready_read", 32'(s_read), 32'd0);

    s_read_at(2'd2, 16'h0033, "rd_a2");
    s_read_at(2'd3, 16'h0044, "rd_a3");
    s_ce = 1'b0;
    s_addr = 2'd0;
    tick();
    chk_eq("rd_hold", 32'(s_q), 32'h0044);

    // Bursty reload with a stray start pulse mid-load.
    sq = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104};
    burst = 1'b1;
    bidx = 0;
    pops = 0;
    viol = 0;
    tick();
    s_pulse();
    chk_eq("reload_done_drop", 32'(s_done), 32'd0);
    chk_eq("reload_busy", 32'(s_busy), 32'd1);
    tick();
    s_pulse();
    wait_pops(4, 60, "burst_timeout");
    chk_eq("burst_done", 32'(s_done), 32'd1);
    repeat (6) tick();
    chk_eq("burst_pops", 32'(pops), 32'd4);
    chk_eq("burst_viol", 32'(viol), 32'd0);
    chk_eq("burst_left", 32'(sq.size()), 32'd1);
    chk_eq("burst_cnt",  32'(s_cnt), 32'd4);
    burst = 1'b0;
    sq.delete();
    for (int i = 0; i < 4; i++)
      s_read_at(2'(i), 16'h0100 + 16'(i), "burst_data");

    // Reset after two of four words.
    sq = '{16'h0200, 16'h0201, 16'h0202, 16'h0203};
    pops = 0;
    tick();
    s_pulse();
    wait_pops(2, 20, "part_timeout");
    rst_n = 1'b0;
    tick();
    chk_eq("abort_done", 32'(s_done), 32'd0);
    chk_eq("abort_busy", 32'(s_busy), 32'd0);
    chk_eq("abort_cnt",  32'(s_cnt),  32'd0);
    chk_eq("abort_q",    32'(s_q),    32'd0);
    chk_eq("abort_pops", 32'(pops),   32'd2);
    sq.delete();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk_eq("start_in_rst", 32'(s_busy), 32'd0);
    s_read_at(2'd1, 16'h0201, "partial_kept");

    // Fresh load; reading addr 0 during its write shows the old word.
    s_addr = 2'd0;
    s_ce = 1'b1;
    sq = '{16'h0300, 16'h0301, 16'h0302, 16'h0303};
    pops = 0;
    tick();
    s_pulse();
    wait_pops(1, 20, "rf_timeout");
    chk_eq("read_first", 32'(s_q), 32'h0200);
    wait_pops(4, 20, "relo_timeout");
    chk_eq("relo_done", 32'(s_done), 32'd1);
    tick();
    chk_eq("relo_a0_new", 32'(s_q), 32'h0300);
    for (int i = 1; i < 4; i++)
      s_read_at(2'(i), 16'h0300 + 16'(i), "relo_data");

    // Full-size instance.
    b_idx = 0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (b_done) break;
      tick();
    end
    chk_eq("big_done", 32'(b_done), 32'd1);
    chk_eq("big_pops", 32'(b_idx), 32'd288);
    chk_eq("big_cnt",  32'(b_cnt), 32'd288);
    repeat (3) tick();
    chk_eq("big_no_extra", 32'(b_idx), 32'd288);
    chk_eq("big_busy", 32'(b_busy), 32'd0);
    b_ce = 1'b1;
    b_addr = 9'd287;
    tick();
    chk_eq("big_a287", 32'(b_q), 32'h811F);
    b_addr = 9'd0;
    tick();
    chk_eq("big_a0", 32'(b_q), 32'h8000);
    b_addr = 9'd288;
    tick();
    chk_eq("big_oor288", 32'(b_q), 32'h8000);
    b_addr = 9'd500;
    tick();
    chk_eq("big_oor500", 32'(b_q), 32'h8000);
    b_ce = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
